// File: rtl/serlink_pkg.sv
// rtl/serlink_pkg.sv - shared frame constants, TX state type and sizing helpers for serlink
package serlink_pkg;

  localparam logic       START_BIT = 1'b1;
  localparam logic [1:0] TRAILER   = 2'b00;

  typedef enum logic { TX_IDLE, TX_SHIFT } tx_state_e;

  function automatic int frame_len(input int dw);
    return dw + 4;
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/serlink_fifo.sv
// rtl/serlink_fifo.sv - synchronous command FIFO with registered level and full/empty flags
module serlink_fifo
  import serlink_pkg::*;
#(
  parameter int  W     = 9,
  parameter int  DEPTH = 16,
  localparam int LW    = level_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_wr_en,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rd_data,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_wr;
  logic          w_rd;

  // Flags come from the registered level, so a full FIFO refuses writes even while popping.
  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/serlink.sv
// rtl/serlink.sv - full-duplex framed serial link: TX FIFO/serialiser, RX decoder, word assembler, timeout
module serlink
  import serlink_pkg::*;
#(
  parameter int  DW     = 8,
  parameter int  NWORD  = 5,
  parameter int  FDEPTH = 16,
  parameter int  TOUT   = 1023,
  localparam int LW     = level_w(FDEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW:0]         tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [LW-1:0]       tx_level,
  output logic                ser_out,
  input  logic                ser_in,
  output logic [DW*NWORD-1:0] rx_word,
  output logic                rx_valid,
  output logic                rx_timeout,
  output logic [15:0]         bytes_sent,
  output logic [15:0]         bytes_seen
);

  localparam int              F         = frame_len(DW);
  localparam int              BW        = $clog2(F);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(F - 1);
  localparam int              AW        = DW * NWORD;
  localparam int              CW        = $clog2(NWORD + 1);
  localparam int              TW        = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
  localparam logic [TW-1:0]   TOUT_LAST = TW'((TOUT > 0) ? TOUT - 1 : 0);

  tx_state_e     r_state;
  tx_state_e     w_state_nx;
  logic [F-1:0]  r_tx_sh;
  logic [BW-1:0] r_bit;
  logic [15:0]   r_bytes_sent;
  logic          w_load;
  logic [DW:0]   w_fifo_dout;
  logic          w_fifo_full;
  logic          w_fifo_empty;

  serlink_fifo #(.W(DW + 1), .DEPTH(FDEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_data (tx_data),
    .i_wr_en   (tx_valid),
    .i_rd_en   (w_load),
    .o_rd_data (w_fifo_dout),
    .o_level   (tx_level),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign tx_ready   = !w_fifo_full;
  assign ser_out    = r_tx_sh[F-1];
  assign bytes_sent = r_bytes_sent;

  // Reloading on the last bit keeps queued frames back-to-back with no idle gap.
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (!w_fifo_empty) begin
          w_load     = 1'b1;
          w_state_nx = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (r_bit == BIT_LAST) begin
          if (!w_fifo_empty) w_load = 1'b1;
          else               w_state_nx = TX_IDLE;
        end
      end
      default: w_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= TX_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_sh      <= '0;
      r_bit        <= '0;
      r_bytes_sent <= '0;
    end else if (w_load) begin
      r_tx_sh      <= {START_BIT, w_fifo_dout, TRAILER};
      r_bit        <= '0;
      r_bytes_sent <= r_bytes_sent + 16'd1;
    end else begin
      r_tx_sh <= r_tx_sh << 1;
      r_bit   <= (r_state == TX_SHIFT) ? r_bit + BW'(1) : '0;
    end
  end

  logic          r_ser_in;
  logic [F-1:0]  r_rx_sh;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_acc_cnt;
  logic [TW-1:0] r_tout_cnt;
  logic [AW-1:0] r_rx_word;
  logic          r_rx_valid;
  logic          r_rx_timeout;
  logic [15:0]   r_bytes_seen;
  logic          w_rx_det;
  logic          w_rx_flag;
  logic [DW-1:0] w_rx_byte;
  logic [AW-1:0] w_acc_next;
  logic          w_tout_hit;

  assign w_rx_det   = r_rx_sh[F-1] && (r_rx_sh[1:0] == TRAILER);
  assign w_rx_flag  = r_rx_sh[F-2];
  assign w_rx_byte  = r_rx_sh[F-3:2];
  assign w_acc_next = (r_acc << DW) | AW'(w_rx_byte);
  assign w_tout_hit = (TOUT != 0) && (r_acc_cnt != '0) && (r_tout_cnt == TOUT_LAST) && !w_rx_det;

  assign rx_word    = r_rx_word;
  assign rx_valid   = r_rx_valid;
  assign rx_timeout = r_rx_timeout;
  assign bytes_seen = r_bytes_seen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ser_in     <= 1'b0;
      r_rx_sh      <= '0;
      r_acc        <= '0;
      r_acc_cnt    <= '0;
      r_tout_cnt   <= '0;
      r_rx_word    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_timeout <= 1'b0;
      r_bytes_seen <= '0;
    end else begin
      r_ser_in     <= ser_in;
      r_rx_valid   <= 1'b0;
      r_rx_timeout <= 1'b0;
      if (w_rx_det) begin
        // Keep the bit just sampled: it may be the start of a back-to-back frame.
        r_rx_sh      <= {{(F-1){1'b0}}, r_ser_in};
        r_bytes_seen <= r_bytes_seen + 16'd1;
        r_tout_cnt   <= '0;
        if (w_rx_flag) begin
          r_rx_valid <= 1'b1;
          r_acc      <= '0;
          r_acc_cnt  <= '0;
        end else begin
          r_acc <= w_acc_next;
          if (r_acc_cnt != CW'(NWORD)) r_acc_cnt <= r_acc_cnt + CW'(1);
        end
      end else begin
        r_rx_sh <= {r_rx_sh[F-2:0], r_ser_in};
        if (w_tout_hit) begin
          r_acc        <= '0;
          r_acc_cnt    <= '0;
          r_tout_cnt   <= '0;
          r_rx_timeout <= 1'b1;
        end else if (r_acc_cnt != '0) begin
          r_tout_cnt <= r_tout_cnt + TW'(1);
        end
      end
      // A completed reply outranks the stale-reply clear from a flagged TX load.
      if (w_rx_det && w_rx_flag)           r_rx_word <= w_acc_next;
      else if (w_load && w_fifo_dout[DW]) r_rx_word <= '0;
    end
  end

endmodule

// File: tb/tb_serlink.sv
// tb/tb_serlink.sv - table-driven loopback bench for serlink with directed corner-case sequences
module tb_serlink;

  localparam int DW = 8, NWORD = 5, FDEPTH = 16, TOUT = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        loop_en = 1'b1;
  logic        ser_drv = 1'b0;
  logic        tx_ready, ser_out, ser_in, rx_valid, rx_timeout;
  logic [4:0]  tx_level;
  logic [39:0] rx_word;
  logic [15:0] bytes_sent, bytes_seen;

  int total = 0;
  int passed = 0;

  assign ser_in = loop_en ? ser_out : ser_drv;

  always #5 clk = ~clk;

  serlink #(.DW(DW), .NWORD(NWORD), .FDEPTH(FDEPTH), .TOUT(TOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_level   (tx_level),
    .ser_out    (ser_out),
    .ser_in     (ser_in),
    .rx_word    (rx_word),
    .rx_valid   (rx_valid),
    .rx_timeout (rx_timeout),
    .bytes_sent (bytes_sent),
    .bytes_seen (bytes_seen)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Writes d[0..n-1] in consecutive cycles starting at cycle 0 and records the line and RX pulses.
  task automatic burst(input logic [8:0] d [8], input int n, input int cycles,
                       output logic [95:0] cap, output int nval, output int lastv, output int ntout);
    cap = '0; nval = 0; lastv = -1; ntout = 0;
    for (int t = 0; t <= cycles; t++) begin
      @(negedge clk);
      if (t >= 2 && t < 2 + 12 * n) cap = {cap[94:0], ser_out};
      if (rx_valid) begin nval++; lastv = t; end
      if (rx_timeout) ntout++;
      tx_valid = (t < n);
      if (t < n) tx_data = d[t];
      else       tx_data = '0;
    end
  endtask

  typedef struct {
    logic [8:0]  din;
    logic [11:0] frame;
    logic [39:0] mid_word;
    logic        is_valid;
    int          lat;
    logic [39:0] word;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [8:0]  d8 [8];
    logic [95:0] cap;
    logic [11:0] exp5 [5];
    logic [23:0] v24;
    logic [11:0] v12;
    int nval, lastv, ntout, guard, ones;

    vecs[0] = '{9'h1A5, 12'hE94, 40'h0,  1'b1, 16, 40'hA5};
    vecs[1] = '{9'h03C, 12'h8F0, 40'hA5, 1'b0, 36, 40'hA5};
    vecs[2] = '{9'h100, 12'hC00, 40'h0,  1'b1, 16, 40'h0};
    vecs[3] = '{9'h15A, 12'hD68, 40'h0,  1'b1, 16, 40'h5A};
    vecs[4] = '{9'h081, 12'hA04, 40'h5A, 1'b0, 36, 40'h5A};
    vecs[5] = '{9'h1FF, 12'hFFC, 40'h0,  1'b1, 16, 40'hFF};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ser_out", ser_out, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_word", rx_word, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_timeout", rx_timeout, 0);
    check("rst_bytes_sent", bytes_sent, 0);
    check("rst_bytes_seen", bytes_seen, 0);

    for (int e = 0; e < 6; e++) begin
      logic [11:0] fcap;
      int          ev_t;
      logic        ev_v;
      logic [39:0] ev_w;
      fcap = '0; ev_t = -1; ev_v = 1'b0; ev_w = '0;
      for (int t = 0; t <= 60; t++) begin
        @(negedge clk);
        if (t >= 2 && t <= 13) fcap = {fcap[10:0], ser_out};
        if (t == 2) check($sformatf("vec%0d_mid_word", e), rx_word, vecs[e].mid_word);
        if (ev_t < 0 && (rx_valid || rx_timeout)) begin
          ev_t = t; ev_v = rx_valid; ev_w = rx_word;
        end
        tx_valid = (t == 0);
        tx_data  = vecs[e].din;
      end
      check($sformatf("vec%0d_frame", e), fcap, vecs[e].frame);
      check($sformatf("vec%0d_event_kind", e), ev_v, vecs[e].is_valid);
      check($sformatf("vec%0d_event_cycle", e), ev_t, vecs[e].lat);
      check($sformatf("vec%0d_word", e), ev_w, vecs[e].word);
    end
    check("vec_bytes_sent", bytes_sent, 6);
    check("vec_bytes_seen", bytes_seen, 6);

    d8 = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h155, 9'h000, 9'h000, 9'h000};
    exp5 = '{12'h844, 12'h888, 12'h8CC, 12'h910, 12'hD54};
    burst(d8, 5, 90, cap, nval, lastv, ntout);
    for (int i = 0; i < 5; i++) check($sformatf("b2b_frame%0d", i), cap[12*(5-i)-1 -: 12], exp5[i]);
    check("b2b_valid_count", nval, 1);
    check("b2b_valid_cycle", lastv, 64);
    check("b2b_timeouts", ntout, 0);
    check("b2b_word", rx_word, 40'h1122334455);

    loop_en = 1'b0;
    do_reset();
    for (int t = 0; t <= 30; t++) begin
      @(negedge clk);
      if (t == 17) begin check("fill_ready_t17", tx_ready, 1); check("fill_level_t17", tx_level, 15); end
      if (t == 18) begin check("fill_ready_t18", tx_ready, 0); check("fill_level_t18", tx_level, 16); end
      if (t == 19) check("fill_level_dropped", tx_level, 16);
      if (t == 25) check("fill_ready_t25", tx_ready, 0);
      if (t == 26) begin check("fill_ready_t26", tx_ready, 1); check("fill_level_t26", tx_level, 15); end
      tx_valid = (t < 19);
      tx_data  = 9'(t);
    end
    guard = 0;
    while (tx_level != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("fill_drain_in_time", guard < 400, 1);
    repeat (15) @(negedge clk);
    check("fill_bytes_sent", bytes_sent, 18);
    check("fill_line_idle", ser_out, 0);

    loop_en = 1'b1;
    d8 = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h007, 9'h108};
    burst(d8, 8, 110, cap, nval, lastv, ntout);
    check("over_valid_count", nval, 1);
    check("over_valid_cycle", lastv, 100);
    check("over_timeouts", ntout, 0);
    check("over_word", rx_word, 40'h0405060708);

    loop_en = 1'b0;
    v24 = {1'b1, 9'h0AB, 2'b00, 1'b1, 9'h0CD, 2'b00};
    ntout = 0;
    for (int t = 0; t <= 50; t++) begin
      @(negedge clk);
      if (t == 25) check("tout_seen_first", bytes_seen, 9);
      if (t == 26) check("tout_seen_second", bytes_seen, 10);
      if (t == 45) check("tout_not_early", rx_timeout, 0);
      if (t == 46) begin check("tout_pulse", rx_timeout, 1); check("tout_word_held", rx_word, 40'h0405060708); end
      if (rx_timeout) ntout++;
      if (t < 24) ser_drv = v24[23-t];
      else        ser_drv = 1'b0;
    end
    check("tout_pulse_count", ntout, 1);
    v12 = {1'b1, 9'h1EE, 2'b00};
    for (int t = 0; t <= 20; t++) begin
      @(negedge clk);
      if (t == 14) begin check("tout_next_valid", rx_valid, 1); check("tout_next_word", rx_word, 40'hEE); end
      if (t < 12) ser_drv = v12[11-t];
      else        ser_drv = 1'b0;
    end
    check("tout_bytes_seen", bytes_seen, 11);

    loop_en = 1'b1;
    ones = 0;
    for (int t = 0; t <= 30; t++) begin
      @(negedge clk);
      if (t == 6) begin
        check("mid_level_before", tx_level, 3);
        check("mid_ser_before", ser_out, 1);
        check("mid_sent_before", bytes_sent, 27);
      end
      if (t == 7) begin
        check("mid_ser_after", ser_out, 0);
        check("mid_level_after", tx_level, 0);
        check("mid_ready_after", tx_ready, 1);
        check("mid_sent_after", bytes_sent, 0);
        check("mid_seen_after", bytes_seen, 0);
        check("mid_word_after", rx_word, 0);
      end
      if (t >= 7 && ser_out) ones++;
      tx_valid = (t < 4);
      tx_data  = 9'h1FF;
      rst_n    = (t != 6);
    end
    check("mid_line_quiet", ones, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
